// File: rtl/counter_pkg.sv
// Shared mode encoding and direction constants for the modulo-N counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_UP       = 2'b00,
    CNT_DOWN     = 2'b01,
    CNT_PINGPONG = 2'b10,
    CNT_HOLD     = 2'b11
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state of a modulo-N counter: next count, next direction, wrap flag.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] MAX_Q = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] q_next,
  output logic             dir_next,
  output logic             wrap
);

  logic at_top;
  logic at_bot;
  logic out_of_range;

  // Anything above MAX_Q counts as the top terminal so a stray value always recovers.
  assign at_top       = (q >= MAX_Q);
  assign at_bot       = (q == '0);
  assign out_of_range = (q > MAX_Q);

  always_comb begin
    q_next   = q;
    dir_next = dir;
    wrap     = 1'b0;
    case (mode)
      CNT_UP: begin
        dir_next = DIR_UP;
        if (at_top) begin
          q_next = '0;
          wrap   = 1'b1;
        end else begin
          q_next = q + 1'b1;
        end
      end
      CNT_DOWN: begin
        dir_next = DIR_DOWN;
        if (at_bot || out_of_range) begin
          q_next = MAX_Q;
          wrap   = 1'b1;
        end else begin
          q_next = q - 1'b1;
        end
      end
      CNT_PINGPONG: begin
        if (dir == DIR_UP || out_of_range) begin
          if (at_top) begin
            q_next   = MAX_Q - 1'b1;
            dir_next = DIR_DOWN;
            wrap     = 1'b1;
          end else begin
            q_next = q + 1'b1;
          end
        end else begin
          if (at_bot) begin
            q_next   = {{(WIDTH-1){1'b0}}, 1'b1};
            dir_next = DIR_UP;
            wrap     = 1'b1;
          end else begin
            q_next = q - 1'b1;
          end
        end
      end
      default: begin
        q_next   = q;
        dir_next = dir;
        wrap     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/negedge_mod_n_counter.sv
// Falling-edge modulo-N up/down/ping-pong counter with load, enable and registered TC.
// Define COUNTER_PRESET_EN to add the asynchronous active-low preset input not_PRE.
module negedge_mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic             CLK,
  input  logic             not_RST,
`ifdef COUNTER_PRESET_EN
  input  logic             not_PRE,
`endif
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic             DIR,
  output logic             TC
);

  generate
    if (WIDTH < 1 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_params
      $error("negedge_mod_n_counter: need WIDTH >= 1 and 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_q;
  logic             step_dir;
  logic             step_wrap;
  cnt_mode_e        mode;

  assign mode = cnt_mode_e'(MODE);

  mod_counter_next #(
    .WIDTH (WIDTH),
    .MAX_Q (MAX_Q)
  ) u_next (
    .q        (q_q),
    .dir      (dir_q),
    .mode     (mode),
    .q_next   (step_q),
    .dir_next (step_dir),
    .wrap     (step_wrap)
  );

  // LOAD beats EN; hold mode only freezes counting, never a load.
  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (LOAD) begin
      q_d = (D > MAX_Q) ? MAX_Q : D;
    end else if (EN && mode != CNT_HOLD) begin
      q_d   = step_q;
      dir_d = step_dir;
      tc_d  = step_wrap;
    end
  end

`ifdef COUNTER_PRESET_EN
  always_ff @(negedge CLK or negedge not_RST or negedge not_PRE) begin
    if (!not_RST) begin
      q_q   <= '0;
      dir_q <= DIR_UP;
      tc_q  <= 1'b0;
    end else if (!not_PRE) begin
      q_q   <= MAX_Q;
      dir_q <= DIR_DOWN;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end
`else
  always_ff @(negedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      q_q   <= '0;
      dir_q <= DIR_UP;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end
`endif

  assign Q   = q_q;
  assign DIR = dir_q;
  assign TC  = tc_q;

endmodule
